// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed FIR with one shared signed MAC, NTAPS taps, runtime coefficient bank
// Optional macro FIR_SEQ_SAT_EN: saturate out_sample on accumulator overflow and add sticky sat_hit output.
module fir_mac_sequencer #(
  parameter int DW     = 16,
  parameter int CW     = 16,
  parameter int TAP_AW = 2,
  parameter int AW     = DW + CW + TAP_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_sample,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_sample,
  input  logic              cfg_we,
  input  logic [TAP_AW-1:0] cfg_addr,
  input  logic [CW-1:0]     cfg_data,
  output logic              cfg_err,
`ifdef FIR_SEQ_SAT_EN
  output logic              sat_hit,
`endif
  output logic              busy
);

  localparam int NTAPS = 2 ** TAP_AW;
  localparam int PW    = DW + CW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0]        r_hist [NTAPS];
  logic [CW-1:0]        r_coef [NTAPS];
  logic signed [AW-1:0] r_acc;
  logic [TAP_AW-1:0]    r_k;
  logic                 r_out_valid;
  logic [DW-1:0]        r_out_sample;
  logic                 r_cfg_err;

  logic                 w_accept;
  logic                 w_cfg_write;
  logic                 w_mac_en;
  logic                 w_mac_last;
  logic                 w_out_load;
  logic                 w_out_done;
  logic signed [PW-1:0] w_hist_x;
  logic signed [PW-1:0] w_coef_x;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_x;
  logic [DW-1:0]        w_out_next;
  logic                 w_unused_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_mac_last = &r_k;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_MAC;
      S_MAC:   if (w_mac_last) w_next = S_OUT;
      S_OUT:   if (w_out_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_cfg_write = 1'b0;
    w_mac_en    = 1'b0;
    w_out_load  = 1'b0;
    w_out_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy        = 1'b0;
        in_ready    = !cfg_we;
        w_cfg_write = cfg_we;
        w_accept    = !cfg_we && in_valid;
      end
      S_MAC: begin
        w_mac_en = 1'b1;
      end
      S_OUT: begin
        // First OUT cycle loads the result register; handshake happens once it is visible.
        w_out_load = !r_out_valid;
        w_out_done = r_out_valid && out_ready;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign w_hist_x = {{CW{r_hist[r_k][DW-1]}}, r_hist[r_k]};
  assign w_coef_x = {{DW{r_coef[r_k][CW-1]}}, r_coef[r_k]};
  assign w_prod   = w_hist_x * w_coef_x;
  assign w_prod_x = {{TAP_AW{w_prod[PW-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= '0;
      end
      r_acc <= '0;
      r_k   <= '0;
    end else begin
      if (w_cfg_write) begin
        r_coef[cfg_addr] <= cfg_data;
      end
      if (w_accept) begin
        r_hist[0] <= in_sample;
        for (int i = 1; i < NTAPS; i++) begin
          r_hist[i] <= r_hist[i-1];
        end
        r_acc <= '0;
        r_k   <= '0;
      end else if (w_mac_en) begin
        r_acc <= r_acc + w_prod_x;
        r_k   <= r_k + TAP_AW'(1);
      end
    end
  end

`ifdef FIR_SEQ_SAT_EN
  logic w_ovf_pos;
  logic w_ovf_neg;
  logic r_sat_hit;

  // Result fits in PW signed bits only when the guard bits all match the sign.
  assign w_ovf_pos = !r_acc[AW-1] && (|r_acc[AW-2:PW-1]);
  assign w_ovf_neg = r_acc[AW-1] && !(&r_acc[AW-2:PW-1]);

  always_comb begin
    w_out_next = r_acc[PW-1:CW];
    if (w_ovf_pos) begin
      w_out_next = {1'b0, {(DW-1){1'b1}}};
    end else if (w_ovf_neg) begin
      w_out_next = {1'b1, {(DW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_hit <= 1'b0;
    end else if (w_out_load && (w_ovf_pos || w_ovf_neg)) begin
      r_sat_hit <= 1'b1;
    end
  end

  assign sat_hit = r_sat_hit;
`else
  assign w_out_next = r_acc[PW-1:CW];
`endif

  assign w_unused_acc = ^r_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && (r_state != S_IDLE);
      if (w_out_load) begin
        r_out_valid  <= 1'b1;
        r_out_sample <= w_out_next;
      end else if (w_out_done) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed and randomized check of fir_mac_sequencer against an arithmetic FIR model
module tb_fir_mac_sequencer;

  localparam int DW     = 16;
  localparam int CW     = 16;
  localparam int TAP_AW = 2;
  localparam int NTAPS  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_sample = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_sample;
  logic              cfg_we = 1'b0;
  logic [TAP_AW-1:0] cfg_addr = '0;
  logic [CW-1:0]     cfg_data = '0;
  logic              cfg_err;
  logic              busy;
`ifdef FIR_SEQ_SAT_EN
  logic              sat_hit;
`endif

  fir_mac_sequencer #(.DW(DW), .CW(CW), .TAP_AW(TAP_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_err    (cfg_err),
`ifdef FIR_SEQ_SAT_EN
    .sat_hit    (sat_hit),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [DW-1:0] m_hist [NTAPS];
  logic signed [CW-1:0] m_coef [NTAPS];
  bit                   m_sat = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint model_sum();
    longint acc = 0;
    for (int i = 0; i < NTAPS; i++) acc += longint'(m_hist[i]) * longint'(m_coef[i]);
    return acc;
  endfunction

  function automatic bit model_overflow();
    longint acc = model_sum();
    return (acc > 64'sd2147483647) || (acc < -64'sd2147483648);
  endfunction

  function automatic logic [15:0] model_result();
    longint      acc = model_sum();
    logic [63:0] bits;
`ifdef FIR_SEQ_SAT_EN
    if (acc > 64'sd2147483647) return 16'h7FFF;
    if (acc < -64'sd2147483648) return 16'h8000;
`endif
    bits = acc;
    return bits[31:16];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      m_hist[i] = '0;
      m_coef[i] = '0;
    end
    m_sat = 1'b0;
  endtask

  task automatic write_coef(input int addr, input logic [15:0] data);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = TAP_AW'(addr);
    cfg_data = data;
    #1 check("in_ready_during_cfg", in_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    m_coef[addr] = data;
  endtask

  task automatic send_sample(input logic [15:0] s, input int stall, input bit bad_cfg,
                             output logic [15:0] got);
    logic [15:0] exp;
    int          n;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_sample = s;
    @(posedge clk);
    for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
    exp = model_result();
    if (model_overflow()) m_sat = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      if (bad_cfg && n == 1) begin
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = 16'h7FFF;
      end
      @(negedge clk);
      n++;
      if (bad_cfg && n == 2) begin
        cfg_we = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
      end
      if (bad_cfg && n == 3) check("cfg_err_once", cfg_err, 0);
    end
    check("latency", n, NTAPS + 1);
    got = out_sample;
    check("out_sample", got, exp);
    check("in_ready_out", in_ready, 0);
    check("busy_out", busy, 1);
`ifdef FIR_SEQ_SAT_EN
    check("sat_hit", sat_hit, m_sat);
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sample = 16'($urandom);
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_sample", out_sample, exp);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] got;
    int          seen;
    model_clear();

    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    write_coef(0, 16'h1000);
    write_coef(1, 16'h2000);
    write_coef(2, 16'h3000);
    write_coef(3, 16'h1000);
    send_sample(16'h4000, 5, 1'b0, got);
    check("dir_first", got, 16'h0400);
    send_sample(16'h4000, 0, 1'b1, got);
    check("dir_second", got, 16'h0C00);
    send_sample(16'h4000, 2, 1'b0, got);
    check("dir_third", got, 16'h1800);
    send_sample(16'h0000, 0, 1'b0, got);
    check("dir_fourth", got, 16'h1800);

    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_data = 16'h0800;
    in_valid = 1'b1;
    in_sample = 16'h1234;
    #1 check("cfg_prio_in_ready", in_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = 1'b0;
    m_coef[0] = 16'h0800;
    check("cfg_prio_not_accepted", busy, 0);
    send_sample(16'h2000, 1, 1'b0, got);

    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'h7FFF);
    for (int i = 0; i < NTAPS; i++) send_sample(16'h7FFF, 0, 1'b0, got);
`ifdef FIR_SEQ_SAT_EN
    check("sat_fourth", got, 16'h7FFF);
    check("sat_hit_set", sat_hit, 1);
`else
    check("wrap_fourth", got, 16'hFFFC);
`endif

    @(negedge clk);
    in_valid = 1'b1;
    in_sample = 16'h4000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sample", out_sample, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cfg_err", cfg_err, 0);
    check("mid_rst_in_ready", in_ready, 1);
`ifdef FIR_SEQ_SAT_EN
    check("mid_rst_sat_hit", sat_hit, 0);
`endif
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_partial_result", seen, 0);
    send_sample(16'h4000, 0, 1'b0, got);
    check("post_rst_zero_coef", got, 16'h0000);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) write_coef($urandom_range(0, NTAPS - 1), 16'($urandom));
      send_sample(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
